// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM states, default
// depth and the byte-lane merge used for partial stores.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int DMEM_DEPTH = 32;

    // Replace the byte lanes of old_word selected by be with the lanes of wdata.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 storage with a single read/write port. Reads are combinational
// so the responder can capture the word at its commit edge; writes are
// byte-masked. The whole array clears asynchronously on reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    // Storage: async clear, otherwise byte-merged write on we_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[addr_i] <= byte_merge(mem_q[addr_i], wdata_i, be_i);
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Word-addressed data-memory target. Accepts one load/store at a time on the
// request channel, waits WAIT_STATES cycles, performs the access on entry to
// RESP and holds the response until the initiator takes it.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = DMEM_DEPTH,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        RN,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept, commit;

    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_be;
    logic        in_range;
    logic [31:0] rd_word;

    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Next-state logic: accept in IDLE, count wait states, commit on RESP entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states the commit coincides with accept, so the access
    // must use the live request rather than the latch.
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_be    = be_q;
        if (state_q == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end
    end

    // Full 32-bit compare: addresses beyond the array never alias into it.
    assign in_range = (acc_addr < 32'(DEPTH));

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk_i   (clk),
        .rst_ni  (RN),
        .we_i    (commit & acc_we & in_range),
        .be_i    (acc_be),
        .addr_i  (acc_addr[AW-1:0]),
        .wdata_i (acc_wdata),
        .rdata_o (rd_word)
    );

    // Response payload is captured once at commit and held through RESP.
    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (commit) begin
            err_d   = !in_range;
            rdata_d = (acc_we || !in_range) ? 32'd0 : rd_word;
        end
    end

    // Control and response registers; reset drops any in-flight request.
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Request latch: loaded only on accept, data path needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_STATES 1, 3, 0) driven by
// directed transactions, checked every cycle against a transaction-level model
// and by literal expectations on selected responses.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int NI    = 3;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic RN  = 1'b0;

    logic [NI-1:0]        req_valid = '0;
    logic [NI-1:0]        req_we    = '0;
    logic [NI-1:0]        rsp_ready = '1;
    logic [NI-1:0][31:0]  req_addr  = '0;
    logic [NI-1:0][31:0]  req_wdata = '0;
    logic [NI-1:0][3:0]   req_be    = '0;
    logic [NI-1:0]        req_ready;
    logic [NI-1:0]        rsp_valid;
    logic [NI-1:0]        rsp_err;
    logic [NI-1:0][31:0]  rsp_rdata;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_responder #(
            .DEPTH       (DEPTH),
            .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 3 : 0))
        ) u_dut (
            .clk       (clk),
            .RN        (RN),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_be    (req_be[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g])
        );
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          m_pend [NI];
    bit          m_rspv [NI];
    int          m_w    [NI];
    logic        m_we   [NI];
    logic [31:0] m_addr [NI];
    logic [31:0] m_wdata[NI];
    logic [3:0]  m_be   [NI];
    logic [31:0] m_rdata[NI];
    logic        m_err  [NI];
    logic [31:0] m_mem  [NI][DEPTH];

    task automatic m_commit(input int k);
        m_pend[k] = 1'b0;
        m_rspv[k] = 1'b1;
        if (m_addr[k] >= 32'(DEPTH)) begin
            m_err[k]   = 1'b1;
            m_rdata[k] = 32'd0;
        end else if (m_we[k]) begin
            m_mem[k][m_addr[k][4:0]] = byte_merge(m_mem[k][m_addr[k][4:0]], m_wdata[k], m_be[k]);
            m_err[k]   = 1'b0;
            m_rdata[k] = 32'd0;
        end else begin
            m_err[k]   = 1'b0;
            m_rdata[k] = m_mem[k][m_addr[k][4:0]];
        end
    endtask

    always @(posedge clk or negedge RN) begin
        if (!RN) begin
            for (int k = 0; k < NI; k++) begin
                m_pend[k] = 1'b0;
                m_rspv[k] = 1'b0;
                m_w[k]    = 0;
                for (int a = 0; a < DEPTH; a++) m_mem[k][a] = 32'd0;
            end
        end else begin
            for (int k = 0; k < NI; k++) begin
                if (m_rspv[k]) begin
                    if (rsp_ready[k]) m_rspv[k] = 1'b0;
                end else if (m_pend[k]) begin
                    m_w[k] = m_w[k] - 1;
                    if (m_w[k] == 0) m_commit(k);
                end else if (req_valid[k]) begin
                    m_we[k]    = req_we[k];
                    m_addr[k]  = req_addr[k];
                    m_wdata[k] = req_wdata[k];
                    m_be[k]    = req_be[k];
                    if (ws_of(k) == 0) begin
                        m_commit(k);
                    end else begin
                        m_w[k]    = ws_of(k);
                        m_pend[k] = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (!RN) begin
                check1($sformatf("ws%0d reset req_ready", ws_of(k)), req_ready[k], 1'b1);
                check1($sformatf("ws%0d reset rsp_valid", ws_of(k)), rsp_valid[k], 1'b0);
                check32($sformatf("ws%0d reset rsp_rdata", ws_of(k)), rsp_rdata[k], 32'd0);
                check1($sformatf("ws%0d reset rsp_err", ws_of(k)), rsp_err[k], 1'b0);
            end else begin
                check1($sformatf("ws%0d req_ready", ws_of(k)), req_ready[k], !(m_pend[k] || m_rspv[k]));
                check1($sformatf("ws%0d rsp_valid", ws_of(k)), rsp_valid[k], m_rspv[k]);
                if (m_rspv[k]) begin
                    check32($sformatf("ws%0d rsp_rdata", ws_of(k)), rsp_rdata[k], m_rdata[k]);
                    check1($sformatf("ws%0d rsp_err", ws_of(k)), rsp_err[k], m_err[k]);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic do_req(input int k, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output logic [31:0] rdata, output logic err, output int lat);
        int t;
        @(posedge clk); #1;
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        req_be[k]    = be;
        t = 0;
        while (!req_ready[k] && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        lat = 1;
        while (!rsp_valid[k] && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check1("response arrives", rsp_valid[k], 1'b1);
        rdata = rsp_rdata[k];
        err   = rsp_err[k];
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] hold;
    int          acc [4];
    logic [31:0] b2b_addr [4] = '{32'd1, 32'd2, 32'd3, 32'd0};
    logic [31:0] b2b_data [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'd0};

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1 RN = 1'b1;
        check1("post-reset req_ready", req_ready[0], 1'b1);
        check1("post-reset rsp_valid", rsp_valid[0], 1'b0);

        // Load from a cleared word, WAIT_STATES=1.
        do_req(0, 1'b0, 32'd3, 32'd0, 4'hF, rd, er, lat);
        check32("load addr3 latency", 32'(lat), 32'd2);
        check32("load addr3 rdata", rd, 32'd0);
        check1("load addr3 err", er, 1'b0);
        check1("ready after handshake", req_ready[0], 1'b1);

        // Full store, byte store, byte-enable-less store, middle-lane store.
        do_req(0, 1'b1, 32'd5, 32'hDEADBEEF, 4'b1111, rd, er, lat);
        check32("store rdata zero", rd, 32'd0);
        do_req(0, 1'b1, 32'd5, 32'h000000AA, 4'b0001, rd, er, lat);
        do_req(0, 1'b0, 32'd5, 32'd0, 4'h0, rd, er, lat);
        check32("merged load addr5", rd, 32'hDEADBEAA);
        do_req(0, 1'b1, 32'd5, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
        check1("be=0 store err", er, 1'b0);
        do_req(0, 1'b0, 32'd5, 32'd0, 4'h0, rd, er, lat);
        check32("be=0 leaves word", rd, 32'hDEADBEAA);
        do_req(0, 1'b1, 32'd5, 32'h00550000, 4'b0100, rd, er, lat);
        do_req(0, 1'b0, 32'd5, 32'd0, 4'h0, rd, er, lat);
        check32("lane2 merge addr5", rd, 32'hDE55BEAA);

        // Out-of-range accesses on the WAIT_STATES=0 instance, then dump it.
        do_req(2, 1'b0, 32'd32, 32'd0, 4'hF, rd, er, lat);
        check1("load addr32 err", er, 1'b1);
        check32("load addr32 rdata", rd, 32'd0);
        do_req(2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'hF, rd, er, lat);
        check1("store top err", er, 1'b1);
        check32("store top rdata", rd, 32'd0);
        do_req(2, 1'b1, 32'd37, 32'hFFFFFFFF, 4'hF, rd, er, lat);
        check1("store addr37 err", er, 1'b1);
        do_req(2, 1'b0, 32'd31, 32'd0, 4'hF, rd, er, lat);
        check1("load addr31 err", er, 1'b0);
        for (int a = 0; a < DEPTH; a++) begin
            do_req(2, 1'b0, 32'(a), 32'd0, 4'hF, rd, er, lat);
            check32($sformatf("dump word %0d", a), rd, 32'd0);
        end

        // Response backpressure with competing requests.
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 32'd5;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        t = 0;
        while (!rsp_valid[0] && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check1("bp rsp_valid", rsp_valid[0], 1'b1);
        hold = rsp_rdata[0];
        check32("bp rdata", hold, 32'hDE55BEAA);
        for (int i = 0; i < 5; i++) begin
            req_valid[0] = (i % 2 == 0);
            req_we[0]    = 1'b1;
            req_addr[0]  = 32'd6;
            req_wdata[0] = 32'hCAFEF00D;
            req_be[0]    = 4'hF;
            @(posedge clk); #1;
            check32("bp rdata stable", rsp_rdata[0], 32'hDE55BEAA);
            check1("bp err stable", rsp_err[0], 1'b0);
            check1("bp ready low", req_ready[0], 1'b0);
            check1("bp valid held", rsp_valid[0], 1'b1);
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        check1("bp ready after handshake", req_ready[0], 1'b1);
        do_req(0, 1'b0, 32'd6, 32'd0, 4'hF, rd, er, lat);
        check32("bp no second accept", rd, 32'd0);

        // Reset while a store waits (WAIT_STATES=3).
        @(posedge clk); #1;
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_addr[1]  = 32'd7;
        req_wdata[1] = 32'h12345678;
        req_be[1]    = 4'hF;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        check1("ws3 busy in wait", req_ready[1], 1'b0);
        @(posedge clk); #1;
        RN = 1'b0;
        #1;
        check1("async reset ready", req_ready[1], 1'b1);
        @(posedge clk); #1;
        RN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check1("dropped store no rsp", rsp_valid[1], 1'b0);
        end
        do_req(1, 1'b0, 32'd7, 32'd0, 4'hF, rd, er, lat);
        check32("ws3 latency", 32'(lat), 32'd4);
        check32("dropped store addr7", rd, 32'd0);

        // Back-to-back loads with zero wait states.
        for (int i = 0; i < 3; i++) begin
            do_req(2, 1'b1, b2b_addr[i], b2b_data[i], 4'hF, rd, er, lat);
            check32("ws0 store latency", 32'(lat), 32'd1);
        end
        @(posedge clk); #1;
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b0;
        req_addr[2]  = b2b_addr[0];
        for (int i = 0; i < 4; i++) begin
            t = 0;
            while (!req_ready[2] && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
            @(posedge clk); #1;
            acc[i] = cyc;
            check1("b2b rsp next cycle", rsp_valid[2], 1'b1);
            check32($sformatf("b2b rdata %0d", i), rsp_rdata[2], b2b_data[i]);
            if (i < 3) req_addr[2] = b2b_addr[i+1];
            else       req_valid[2] = 1'b0;
            if (i > 0) check32("b2b spacing", 32'(acc[i] - acc[i-1]), 32'd2);
        end
        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
